// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp values, R-type funct codes
// and the multiplier state type.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/ex_stage_multu_seq.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle,
// WIDTH steps, product left in {hi, lo}.
module multu_seq
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sum     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Carry out of the add lands in sum[WIDTH] and shifts down into HI.
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        hi_d  = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU-control decode, combinational ALU, HI/LO multiplier and
// the EX/WB boundary registers. Stall holds upstream while multu iterates.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALUOp,
  input  logic             RegWrite,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic [5:0]       Funct,
  input  logic [4:0]       Shamt,
  input  logic [4:0]       RdAddr,
  output logic [WIDTH-1:0] ResultOut,
  output logic             RegWriteOut,
  output logic [4:0]       RdAddrOut,
  output logic             Stall
);

  logic             busy;
  logic             mult_start;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] alu_res;
  logic             slt_bit;

  logic [WIDTH-1:0] result_q, result_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_addr_q, rd_addr_d;

  assign mult_start = !busy && (ALUOp == ALUOP_RTYPE) && (Funct == FN_MULTU);
  assign slt_bit    = $signed(RsData) < $signed(RtData);

  multu_seq #(
    .WIDTH(WIDTH)
  ) u_multu (
    .clk  (clk),
    .rst  (rst),
    .start(mult_start),
    .a    (RsData),
    .b    (RtData),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always_comb begin
    alu_res = '0;
    unique case (ALUOp)
      ALUOP_SUB:   alu_res = RsData - RtData;
      ALUOP_RTYPE: begin
        unique case (Funct)
          FN_ADD:  alu_res = RsData + RtData;
          FN_SUB:  alu_res = RsData - RtData;
          FN_AND:  alu_res = RsData & RtData;
          FN_OR:   alu_res = RsData | RtData;
          FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
          FN_SLL:  alu_res = RtData << Shamt;
          FN_SRL:  alu_res = RtData >> Shamt;
          FN_SRA:  alu_res = $signed(RtData) >>> Shamt;
          FN_MFHI: alu_res = hi;
          FN_MFLO: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
      default:     alu_res = RsData + RtData;
    endcase
  end

  // multu and every busy cycle retire as a bubble; multu never writes a GPR.
  always_comb begin
    result_d    = alu_res;
    reg_write_d = RegWrite;
    rd_addr_d   = RdAddr;
    if (busy || mult_start) begin
      result_d    = '0;
      reg_write_d = 1'b0;
      rd_addr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      result_q    <= result_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign ResultOut   = result_q;
  assign RegWriteOut = reg_write_q;
  assign RdAddrOut   = rd_addr_q;
  assign Stall       = busy;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes the expected EX/WB output
// for every cycle it drives; a monitor pops and compares after each edge.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [31:0] rs_data, rt_data;
  logic [5:0]  funct;
  logic [4:0]  shamt, rd_addr;
  logic [31:0] result_out;
  logic        reg_write_out;
  logic [4:0]  rd_addr_out;
  logic        stall;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        rw;
    logic [4:0]  rd;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  ex_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUOp      (alu_op),
    .RegWrite   (reg_write),
    .RsData     (rs_data),
    .RtData     (rt_data),
    .Funct      (funct),
    .Shamt      (shamt),
    .RdAddr     (rd_addr),
    .ResultOut  (result_out),
    .RegWriteOut(reg_write_out),
    .RdAddrOut  (rd_addr_out),
    .Stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input string nm, input logic r, input logic [1:0] op,
                       input logic rw, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [5:0] fn, input logic [4:0] sh, input logic [4:0] rd,
                       input logic [31:0] eres, input logic erw, input logic [4:0] erd,
                       input logic est);
    exp_t e;
    @(negedge clk);
    rst = r; alu_op = op; reg_write = rw; rs_data = rs; rt_data = rt;
    funct = fn; shamt = sh; rd_addr = rd;
    e.name = nm; e.res = eres; e.rw = erw; e.rd = erd; e.st = est;
    sb.push_back(e);
  endtask

  // Monitor: the EX/WB boundary presents a new output every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (result_out !== e.res || reg_write_out !== e.rw ||
            rd_addr_out !== e.rd || stall !== e.st) begin
          miscompares++;
          $display("FAIL %s: got res=%h rw=%b rd=%0d stall=%b, want res=%h rw=%b rd=%0d stall=%b",
                   e.name, result_out, reg_write_out, rd_addr_out, stall,
                   e.res, e.rw, e.rd, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_op = '0; reg_write = 1'b0; rs_data = '0; rt_data = '0;
    funct = '0; shamt = '0; rd_addr = '0;

    drive("reset", 1, ALUOP_RTYPE, 1, 32'h1234, 32'h1, FN_ADD, 0, 5'd4, 0, 0, 0, 0);
    drive("add_wrap", 0, ALUOP_RTYPE, 1, 32'h7FFFFFFF, 32'h1, FN_ADD, 0, 5'd5,
          32'h80000000, 1, 5'd5, 0);
    drive("sub_neg", 0, ALUOP_RTYPE, 1, 32'h0, 32'h1, FN_SUB, 0, 5'd6,
          32'hFFFFFFFF, 1, 5'd6, 0);
    drive("slt_true", 0, ALUOP_RTYPE, 1, 32'hFFFFFFFF, 32'h1, FN_SLT, 0, 5'd7, 32'h1, 1, 5'd7, 0);
    drive("slt_false", 0, ALUOP_RTYPE, 1, 32'h1, 32'hFFFFFFFF, FN_SLT, 0, 5'd7, 32'h0, 1, 5'd7, 0);
    drive("sll", 0, ALUOP_RTYPE, 1, 32'h0, 32'h80000001, FN_SLL, 5'd4, 5'd1, 32'h00000010, 1, 5'd1, 0);
    drive("srl", 0, ALUOP_RTYPE, 1, 32'h0, 32'h80000001, FN_SRL, 5'd4, 5'd2, 32'h08000000, 1, 5'd2, 0);
    drive("sra", 0, ALUOP_RTYPE, 1, 32'h0, 32'h80000001, FN_SRA, 5'd4, 5'd3, 32'hF8000000, 1, 5'd3, 0);
    drive("and", 0, ALUOP_RTYPE, 1, 32'hF0F01234, 32'h0FF0FFFF, FN_AND, 0, 5'd10,
          32'h00F01234, 1, 5'd10, 0);
    drive("or", 0, ALUOP_RTYPE, 1, 32'hF0F01234, 32'h0FF0FFFF, FN_OR, 0, 5'd11,
          32'hFFF0FFFF, 1, 5'd11, 0);
    drive("bad_funct", 0, ALUOP_RTYPE, 1, 32'h5, 32'h6, 6'h3F, 0, 5'd12, 32'h0, 1, 5'd12, 0);
    drive("aluop_add", 0, ALUOP_ADD, 0, 32'h2, 32'h3, 6'h3F, 0, 5'd13, 32'h5, 0, 5'd13, 0);
    drive("aluop_sub", 0, ALUOP_SUB, 1, 32'hA, 32'h3, 6'h3F, 0, 5'd14, 32'h7, 1, 5'd14, 0);
    drive("aluop_rsvd", 0, ALUOP_RSVD, 1, 32'h2, 32'h3, FN_SUB, 0, 5'd15, 32'h5, 1, 5'd15, 0);
    drive("mfhi_reset", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd16, 32'h0, 1, 5'd16, 0);

    // multu max x max; mfhi is held upstream for the whole stall window
    drive("multu_issue", 0, ALUOP_RTYPE, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, FN_MULTU, 0, 5'd3, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++)
      drive("multu_busy", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 0, 0, 0, 1);
    drive("multu_done", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 0, 0, 0, 0);
    drive("mfhi_max", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 32'hFFFFFFFE, 1, 5'd8, 0);
    drive("mflo_max", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFLO, 0, 5'd9, 32'h00000001, 1, 5'd9, 0);

    // reset on the tenth busy cycle aborts the multiply
    drive("abort_issue", 0, ALUOP_RTYPE, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, FN_MULTU, 0, 5'd3, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++)
      drive("abort_busy", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 0, 0, 0, 1);
    drive("abort_rst", 1, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 0, 0, 0, 0);
    drive("abort_mfhi", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 32'h0, 1, 5'd8, 0);
    drive("abort_mflo", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFLO, 0, 5'd9, 32'h0, 1, 5'd9, 0);

    // back-to-back multu: second one waits upstream, then restarts cleanly
    drive("b2b_issue1", 0, ALUOP_RTYPE, 1, 32'd3, 32'd5, FN_MULTU, 0, 5'd3, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++)
      drive("b2b_busy1", 0, ALUOP_RTYPE, 1, 32'd7, 32'd9, FN_MULTU, 0, 5'd3, 0, 0, 0, 1);
    drive("b2b_gap", 0, ALUOP_RTYPE, 1, 32'd7, 32'd9, FN_MULTU, 0, 5'd3, 0, 0, 0, 0);
    drive("b2b_issue2", 0, ALUOP_RTYPE, 1, 32'd7, 32'd9, FN_MULTU, 0, 5'd3, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++)
      drive("b2b_busy2", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFLO, 0, 5'd9, 0, 0, 0, 1);
    drive("b2b_done", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFLO, 0, 5'd9, 0, 0, 0, 0);
    drive("b2b_mflo", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFLO, 0, 5'd9, 32'd63, 1, 5'd9, 0);
    drive("b2b_mfhi", 0, ALUOP_RTYPE, 1, 32'h0, 32'h0, FN_MFHI, 0, 5'd8, 32'd0, 1, 5'd8, 0);
    drive("post_add", 0, ALUOP_RTYPE, 1, 32'd100, 32'd23, FN_ADD, 0, 5'd31, 32'd123, 1, 5'd31, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
